// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM encoding, instruction size, reset PC and FIFO entry layout.
package fetch_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0001_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, ir} entries; flush beats push/pop, push into a full FIFO is
// accepted when a pop frees the slot in the same cycle.
module fetch_unit_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  fetch_entry_t                 data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output fetch_entry_t                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            full_c;
  logic            do_pop_c;
  logic            do_push_c;

  assign full_c    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_pop_c  = pop_i && !empty_o;
  assign do_push_c = push_i && (!full_c || do_pop_c);
  assign count_o   = count_q;
  assign head_o    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem read at a time, buffers
// returned words for decode and squashes stale fetches on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ir_valid_o,
  input  logic        ir_ready_i,
  output logic [31:0] ir_o,
  output logic [31:0] pc_o
);

  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam logic [31:0] PC_MASK = ~32'(INSTR_BYTES - 1);

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          discard_q, discard_d;

  logic          ack_c;
  logic          push_c;
  logic          pop_c;
  logic          empty_c;
  logic [CW-1:0] count_c;
  logic [CW-1:0] count_next_c;
  fetch_entry_t  push_data_c;
  fetch_entry_t  head_c;

  assign ack_c       = (state_q == ST_REQ) && imem_ack_i;
  assign pop_c       = !empty_c && ir_ready_i;
  assign push_c      = ack_c && !discard_q && !redirect_i;
  assign push_data_c = '{pc: fetch_pc_q, ir: imem_rdata_i};

  // Next PC, discard flag and request issue; a new request follows an ack directly when a slot remains.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    addr_d       = addr_q;
    discard_d    = discard_q;
    count_next_c = count_c + CW'(push_c) - CW'(pop_c);

    if (push_c) fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
    if (redirect_i) begin
      fetch_pc_d   = redirect_pc_i & PC_MASK;
      count_next_c = '0;
    end

    if (ack_c) discard_d = 1'b0;
    else if (redirect_i && (state_q == ST_REQ)) discard_d = 1'b1;

    // The bus address must not move while a request waits for its ack.
    if ((state_q == ST_IDLE) || imem_ack_i) begin
      state_d = (count_next_c < CW'(DEPTH)) ? ST_REQ : ST_IDLE;
      addr_d  = fetch_pc_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
    end
  end

  fetch_unit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .data_i  (push_data_c),
    .pop_i   (pop_c),
    .flush_i (redirect_i),
    .head_o  (head_c),
    .count_o (count_c),
    .empty_o (empty_c)
  );

  assign imem_req_o  = (state_q == ST_REQ);
  assign imem_addr_o = addr_q;
  assign ir_valid_o  = !empty_c;
  assign ir_o        = head_c.ir;
  assign pc_o        = head_c.pc;

endmodule
